// File: rtl/obstacle_if.sv
// ---------------------------------------------------------------------------
// obstacle_if : car position in, obstacle/score/game status out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface obstacle_if;
  logic        start_n;
  logic [9:0]  car_h_pos;
  logic [8:0]  car_v_pos;
  logic [9:0]  obs_h_pos;
  logic [8:0]  obs_v_pos;
  logic [15:0] score;
  logic [3:0]  speed;
  logic [1:0]  game_state;
  logic        collision;
  logic        reset_game;

  modport master (
    input  start_n, car_h_pos, car_v_pos,
    output obs_h_pos, obs_v_pos, score, speed, game_state, collision, reset_game
  );

  modport slave (
    output start_n, car_h_pos, car_v_pos,
    input  obs_h_pos, obs_v_pos, score, speed, game_state, collision, reset_game
  );
endinterface

`default_nettype wire

// File: rtl/obstacle_engine.sv
// ---------------------------------------------------------------------------
// obstacle_engine : falling-obstacle game logic, collision, score and FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module obstacle_engine #(
  parameter logic [25:0] TICK_DIV    = 26'd833_334,
  parameter logic [9:0]  PISTA_ESQ   = 10'd120,
  parameter logic [9:0]  PISTA_DIR   = 10'd520,
  parameter logic [9:0]  CAR_W       = 10'd50,
  parameter logic [8:0]  CAR_H       = 9'd80,
  parameter logic [9:0]  OBS_W       = 10'd50,
  parameter logic [8:0]  OBS_H       = 9'd80,
  parameter logic [8:0]  SCREEN_H    = 9'd480,
  parameter logic [3:0]  VEL_INI     = 4'd4,
  parameter logic [3:0]  VEL_MAX     = 4'd12,
  parameter logic [7:0]  CRASH_TICKS = 8'd60
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  obstacle_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2
  } state_t;

  // Offset range so that the obstacle's right edge never passes PISTA_DIR
  localparam logic [9:0] SPAWN_RANGE = PISTA_DIR - PISTA_ESQ - OBS_W;

  state_t      state, state_nxt;
  logic [25:0] tick_cnt;
  logic        tick;
  logic [9:0]  lfsr;
  logic [9:0]  obs_h, obs_h_nxt;
  logic [8:0]  obs_v, obs_v_nxt;
  logic [15:0] score_cnt, score_nxt;
  logic [3:0]  fall_speed, speed_nxt;
  logic [3:0]  level_cnt, level_nxt;
  logic [7:0]  crash_cnt, crash_nxt;
  logic        collision_flag, reset_pulse, reset_pulse_nxt;

  logic [9:0]  lfsr_x;
  logic [9:0]  spawn_off;
  logic [9:0]  spawn_h;
  logic [8:0]  nv;
  logic        overlap;

  assign tick = (tick_cnt == TICK_DIV - 26'd1);

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      tick_cnt <= 26'd0;
      lfsr     <= 10'h001;
    end else begin
      tick_cnt <= tick ? 26'd0 : tick_cnt + 26'd1;
      lfsr     <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  end

  assign lfsr_x    = {1'b0, lfsr[8:0]};
  assign spawn_off = (lfsr_x >= SPAWN_RANGE) ? (lfsr_x - SPAWN_RANGE) : lfsr_x;
  assign spawn_h   = PISTA_ESQ + spawn_off;

  // Widened so the right/bottom edge sums cannot wrap
  logic [10:0] car_h11, car_v11, obs_h11, obs_v11;
  assign car_h11 = {1'b0, bus.car_h_pos};
  assign car_v11 = {2'b00, bus.car_v_pos};
  assign obs_h11 = {1'b0, obs_h};
  assign obs_v11 = {2'b00, obs_v};

  assign overlap = (car_h11 < obs_h11 + {1'b0, OBS_W}) &&
                   (obs_h11 < car_h11 + {1'b0, CAR_W}) &&
                   (car_v11 < obs_v11 + {2'b00, OBS_H}) &&
                   (obs_v11 < car_v11 + {2'b00, CAR_H});

  assign nv = obs_v + {5'd0, fall_speed};

  always_comb begin
    state_nxt       = state;
    obs_h_nxt       = obs_h;
    obs_v_nxt       = obs_v;
    score_nxt       = score_cnt;
    speed_nxt       = fall_speed;
    level_nxt       = level_cnt;
    crash_nxt       = crash_cnt;
    reset_pulse_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.start_n) begin
          state_nxt = RUN;
          score_nxt = 16'd0;
          speed_nxt = VEL_INI;
          level_nxt = 4'd0;
          obs_v_nxt = 9'd0;
          obs_h_nxt = spawn_h;
        end
      end

      RUN: begin
        if (overlap) begin
          state_nxt = CRASH;
        end else if (tick) begin
          if (nv >= SCREEN_H) begin
            obs_v_nxt = 9'd0;
            obs_h_nxt = spawn_h;
            score_nxt = (score_cnt == 16'hFFFF) ? score_cnt : score_cnt + 16'd1;
            if (level_cnt == 4'd9) begin
              level_nxt = 4'd0;
              if (fall_speed < VEL_MAX)
                speed_nxt = fall_speed + 4'd1;
            end else begin
              level_nxt = level_cnt + 4'd1;
            end
          end else begin
            obs_v_nxt = nv;
          end
        end
      end

      CRASH: begin
        if (tick) begin
          if (crash_cnt == CRASH_TICKS - 8'd1) begin
            state_nxt       = IDLE;
            crash_nxt       = 8'd0;
            reset_pulse_nxt = 1'b1;
          end else begin
            crash_nxt = crash_cnt + 8'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state          <= IDLE;
      obs_h          <= 10'd220;
      obs_v          <= 9'd0;
      score_cnt      <= 16'd0;
      fall_speed     <= VEL_INI;
      level_cnt      <= 4'd0;
      crash_cnt      <= 8'd0;
      collision_flag <= 1'b0;
      reset_pulse    <= 1'b0;
    end else begin
      state          <= state_nxt;
      obs_h          <= obs_h_nxt;
      obs_v          <= obs_v_nxt;
      score_cnt      <= score_nxt;
      fall_speed     <= speed_nxt;
      level_cnt      <= level_nxt;
      crash_cnt      <= crash_nxt;
      collision_flag <= (state_nxt == CRASH);
      reset_pulse    <= reset_pulse_nxt;
    end
  end

  assign bus.obs_h_pos  = obs_h;
  assign bus.obs_v_pos  = obs_v;
  assign bus.score      = score_cnt;
  assign bus.speed      = fall_speed;
  assign bus.game_state = state;
  assign bus.collision  = collision_flag;
  assign bus.reset_game = reset_pulse;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_engine.sv
// ---------------------------------------------------------------------------
// tb_obstacle_engine : scoreboard bench for obstacle_engine (fast tick)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_obstacle_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;

  obstacle_if bus ();

  obstacle_engine #(
    .TICK_DIV    (26'd4),
    .CRASH_TICKS (8'd3)
  ) dut (
    .iVGA_CLK (clk),
    .iRST     (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  v;
    logic [15:0] s;
    logic [3:0]  sp;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   fails  = 0;
  logic mon_en = 1'b0;
  logic [8:0] prev_v = 9'd0;

  // Reference game state, advanced one tick at a time
  int m_v, m_score, m_speed, m_level;

  // Every obstacle move is popped against the next expected position
  always @(posedge clk) begin
    #1;
    if (mon_en && bus.obs_v_pos !== prev_v) begin
      if (sbq.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_move obs_v=%0d required no change from %0d", bus.obs_v_pos, prev_v);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (bus.obs_v_pos !== e.v) begin
          fails++; $display("FAIL sb_obs_v got %0d required %0d", bus.obs_v_pos, e.v);
        end
        checks++;
        if (bus.score !== e.s) begin
          fails++; $display("FAIL sb_score got %0d required %0d", bus.score, e.s);
        end
        checks++;
        if (bus.speed !== e.sp) begin
          fails++; $display("FAIL sb_speed got %0d required %0d", bus.speed, e.sp);
        end
        if (e.v == 9'd0) begin
          checks++;
          if (bus.obs_h_pos < 10'd120 || bus.obs_h_pos > 10'd469) begin
            fails++; $display("FAIL sb_spawn_h got %0d required 120..469", bus.obs_h_pos);
          end
        end
      end
    end
    prev_v = bus.obs_v_pos;
  end

  task automatic model_tick();
    exp_t x;
    m_v = m_v + m_speed;
    if (m_v >= 480) begin
      m_v = 0;
      if (m_score < 65535) m_score++;
      m_level++;
      if (m_level == 10) begin
        m_level = 0;
        if (m_speed < 12) m_speed++;
      end
    end
    x.v = m_v[8:0]; x.s = m_score[15:0]; x.sp = m_speed[3:0];
    sbq.push_back(x);
  endtask

  task automatic drain(input string name);
    int budget;
    int n;
    budget = sbq.size() * 4 + 16;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout got %0d pending required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic start_game();
    mon_en = 1'b0;
    @(negedge clk);
    bus.start_n = 1'b0;
    @(negedge clk);
    bus.start_n = 1'b1;
    checks++;
    if (bus.game_state !== 2'd1) begin
      fails++; $display("FAIL start_state got %0d required 1", bus.game_state);
    end
    checks++;
    if (bus.score !== 16'd0 || bus.speed !== 4'd4 || bus.obs_v_pos !== 9'd0) begin
      fails++;
      $display("FAIL start_values got score=%0d speed=%0d obs_v=%0d required 0/4/0",
               bus.score, bus.speed, bus.obs_v_pos);
    end
    m_v = 0; m_score = 0; m_speed = 4; m_level = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    bus.start_n   = 1'b1;
    bus.car_h_pos = 10'd0;
    bus.car_v_pos = 9'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.game_state !== 2'd0 || bus.obs_h_pos !== 10'd220 || bus.obs_v_pos !== 9'd0 ||
        bus.score !== 16'd0 || bus.speed !== 4'd4 || bus.collision !== 1'b0 ||
        bus.reset_game !== 1'b0) begin
      fails++;
      $display("FAIL reset_values got st=%0d h=%0d v=%0d sc=%0d sp=%0d col=%b rg=%b required 0/220/0/0/4/0/0",
               bus.game_state, bus.obs_h_pos, bus.obs_v_pos, bus.score, bus.speed,
               bus.collision, bus.reset_game);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.game_state !== 2'd0 || bus.obs_v_pos !== 9'd0) begin
      fails++; $display("FAIL idle_hold got st=%0d v=%0d required 0/0", bus.game_state, bus.obs_v_pos);
    end
  endtask

  task automatic test_start();
    start_game();
    model_tick();
    drain("first_tick");
    checks++;
    if (bus.obs_v_pos !== 9'd4) begin
      fails++; $display("FAIL first_tick_v got %0d required 4", bus.obs_v_pos);
    end
  endtask

  task automatic test_respawn();
    while (m_score < 1) model_tick();
    drain("respawn1");
    checks++;
    if (bus.score !== 16'd1 || bus.obs_v_pos !== 9'd0) begin
      fails++; $display("FAIL respawn1 got score=%0d v=%0d required 1/0", bus.score, bus.obs_v_pos);
    end
    while (m_score < 10) model_tick();
    drain("respawn10");
    checks++;
    if (bus.speed !== 4'd5) begin
      fails++; $display("FAIL speed_after10 got %0d required 5", bus.speed);
    end
    while (m_score < 90) model_tick();
    drain("respawn90");
    checks++;
    if (bus.speed !== 4'd12) begin
      fails++; $display("FAIL speed_after90 got %0d required 12", bus.speed);
    end
    while (m_score < 100) model_tick();
    drain("respawn100");
    checks++;
    if (bus.speed !== 4'd12 || bus.score !== 16'd100) begin
      fails++; $display("FAIL speed_after100 got speed=%0d score=%0d required 12/100", bus.speed, bus.score);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    mon_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.game_state !== 2'd0 || bus.obs_h_pos !== 10'd220 || bus.obs_v_pos !== 9'd0 ||
        bus.score !== 16'd0 || bus.speed !== 4'd4 || bus.collision !== 1'b0 ||
        bus.reset_game !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got st=%0d h=%0d v=%0d sc=%0d sp=%0d col=%b rg=%b required 0/220/0/0/4/0/0",
               bus.game_state, bus.obs_h_pos, bus.obs_v_pos, bus.score, bus.speed,
               bus.collision, bus.reset_game);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.reset_game !== 1'b0 || bus.game_state !== 2'd0) begin
      fails++; $display("FAIL post_reset got rg=%b st=%0d required 0/0", bus.reset_game, bus.game_state);
    end
  endtask

  task automatic test_crash();
    int n;
    bus.car_h_pos = 10'd0;
    bus.car_v_pos = 9'd400;
    start_game();
    while (m_score < 1) model_tick();
    drain("crash_pre");
    bus.car_h_pos = bus.obs_h_pos;
    while (m_v < 324) model_tick();
    drain("crash_fall");
    @(negedge clk);
    checks++;
    if (bus.game_state !== 2'd2 || bus.collision !== 1'b1 || bus.obs_v_pos !== 9'd324) begin
      fails++;
      $display("FAIL crash_entry got st=%0d col=%b v=%0d required 2/1/324",
               bus.game_state, bus.collision, bus.obs_v_pos);
    end
    bus.start_n = 1'b0;
    n = 0;
    while (bus.reset_game !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    mon_en = 1'b0;
    checks++;
    if (n != 11) begin
      fails++; $display("FAIL crash_duration got %0d clocks required 11", n);
    end
    checks++;
    if (bus.game_state !== 2'd0 || bus.score !== 16'd1 || bus.collision !== 1'b0) begin
      fails++;
      $display("FAIL crash_exit got st=%0d score=%0d col=%b required 0/1/0",
               bus.game_state, bus.score, bus.collision);
    end
    bus.car_h_pos = 10'd0;
    @(negedge clk);
    bus.start_n = 1'b1;
    checks++;
    if (bus.reset_game !== 1'b0 || bus.game_state !== 2'd1 || bus.score !== 16'd0 || bus.speed !== 4'd4) begin
      fails++;
      $display("FAIL held_restart got rg=%b st=%0d score=%0d speed=%0d required 0/1/0/4",
               bus.reset_game, bus.game_state, bus.score, bus.speed);
    end
  endtask

  task automatic test_crash_on_tick();
    int n;
    n = 0;
    while (bus.obs_v_pos === 9'd0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.obs_v_pos !== 9'd4) begin
      fails++; $display("FAIL tick_phase got v=%0d required 4", bus.obs_v_pos);
    end
    repeat (3) @(negedge clk);
    bus.car_h_pos = bus.obs_h_pos;
    bus.car_v_pos = 9'd0;
    @(negedge clk);
    checks++;
    if (bus.game_state !== 2'd2 || bus.obs_v_pos !== 9'd4 || bus.collision !== 1'b1) begin
      fails++;
      $display("FAIL tick_overlap got st=%0d v=%0d col=%b required 2/4/1",
               bus.game_state, bus.obs_v_pos, bus.collision);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.obs_v_pos !== 9'd4 || bus.game_state !== 2'd2) begin
      fails++; $display("FAIL crash_frozen got v=%0d st=%0d required 4/2", bus.obs_v_pos, bus.game_state);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_respawn();
    test_reset_mid_run();
    test_crash();
    test_crash_on_tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
